// File: rtl/fabric_stimulus_driver.sv
// rtl/fabric_stimulus_driver.sv - serial config bitstream loader followed by data-in vector driver
// Shifts CONFIG_WIDTH bits MSB-first from sequencer words, applies NUM_VECTORS vectors, flags sim_done.
module fabric_stimulus_driver #(
  parameter int DATA_IN_WIRE_WIDTH = 16,
  parameter int CONFIG_WIDTH       = 64,
  parameter int WORD_WIDTH         = 8,
  parameter int NUM_VECTORS        = 256
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [WORD_WIDTH-1:0]         cfg_word,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic                          config_in,
  output logic                          config_en,
  output logic                          config_done,
  input  logic [DATA_IN_WIRE_WIDTH-1:0] vec_data,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  output logic [DATA_IN_WIRE_WIDTH-1:0] datain,
  output logic                          datain_valid,
  output logic                          sim_done,
  output logic                          busy
);

  localparam int TW  = $clog2(CONFIG_WIDTH + 1);
  localparam int WCW = $clog2(WORD_WIDTH + 1);
  localparam int VW  = $clog2(NUM_VECTORS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_VEC, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [WORD_WIDTH-1:0]           shreg_q, shreg_d;
  logic [WCW-1:0]                  word_cnt_q, word_cnt_d;
  logic [TW-1:0]                   total_q, total_d;
  logic [VW-1:0]                   vec_cnt_q, vec_cnt_d;
  logic                            cfg_ready_q, cfg_ready_d;
  logic                            config_in_q, config_in_d;
  logic                            config_en_q, config_en_d;
  logic                            config_done_q, config_done_d;
  logic                            vec_ready_q, vec_ready_d;
  logic [DATA_IN_WIRE_WIDTH-1:0]   datain_q, datain_d;
  logic                            datain_valid_q, datain_valid_d;
  logic                            sim_done_q, sim_done_d;
  logic                            busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    word_cnt_d     = word_cnt_q;
    total_d        = total_q;
    vec_cnt_d      = vec_cnt_q;
    config_in_d    = 1'b0;
    config_en_d    = 1'b0;
    config_done_d  = config_done_q;
    datain_d       = datain_q;
    datain_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          config_done_d = 1'b0;
          total_d       = '0;
          vec_cnt_d     = '0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        // The captured word's MSB goes straight to the output so it appears the cycle after the handshake.
        if (cfg_valid && cfg_ready_q) begin
          config_in_d = cfg_word[WORD_WIDTH-1];
          config_en_d = 1'b1;
          shreg_d     = cfg_word << 1;
          word_cnt_d  = WCW'(1);
          total_d     = total_q + TW'(1);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (total_q == TW'(CONFIG_WIDTH)) begin
          config_done_d = 1'b1;
          state_d       = S_VEC;
        end else if (word_cnt_q == WCW'(WORD_WIDTH)) begin
          state_d = S_LOAD;
        end else begin
          config_in_d = shreg_q[WORD_WIDTH-1];
          config_en_d = 1'b1;
          shreg_d     = shreg_q << 1;
          word_cnt_d  = word_cnt_q + WCW'(1);
          total_d     = total_q + TW'(1);
        end
      end
      S_VEC: begin
        if (vec_valid && vec_ready_q) begin
          datain_d       = vec_data;
          datain_valid_d = 1'b1;
          vec_cnt_d      = vec_cnt_q + VW'(1);
          if (vec_cnt_q == VW'(NUM_VECTORS - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake-facing outputs follow the next state so they are valid in the state's first cycle.
    cfg_ready_d = (state_d == S_LOAD);
    vec_ready_d = (state_d == S_VEC);
    sim_done_d  = (state_d == S_DONE);
    busy_d      = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_VEC);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      word_cnt_q     <= '0;
      total_q        <= '0;
      vec_cnt_q      <= '0;
      cfg_ready_q    <= 1'b0;
      config_in_q    <= 1'b0;
      config_en_q    <= 1'b0;
      config_done_q  <= 1'b0;
      vec_ready_q    <= 1'b0;
      datain_q       <= '0;
      datain_valid_q <= 1'b0;
      sim_done_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      word_cnt_q     <= word_cnt_d;
      total_q        <= total_d;
      vec_cnt_q      <= vec_cnt_d;
      cfg_ready_q    <= cfg_ready_d;
      config_in_q    <= config_in_d;
      config_en_q    <= config_en_d;
      config_done_q  <= config_done_d;
      vec_ready_q    <= vec_ready_d;
      datain_q       <= datain_d;
      datain_valid_q <= datain_valid_d;
      sim_done_q     <= sim_done_d;
      busy_q         <= busy_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign config_in    = config_in_q;
  assign config_en    = config_en_q;
  assign config_done  = config_done_q;
  assign vec_ready    = vec_ready_q;
  assign datain       = datain_q;
  assign datain_valid = datain_valid_q;
  assign sim_done     = sim_done_q;
  assign busy         = busy_q;

endmodule
